run_sequencer: RTL and testbench

- Top-level controller for the 3-bit-opcode execute datapath.
- Loads the 48-bit A/B/C initial values into the datapath bit-serially by pulsing its init_regs path. Holds the program image in a small opcode memory.
- Launches and monitors a run, and buffers emitted 3-bit outputs in a FIFO for host readout.
- Sits between the host/test-harness interface and the fetch/decode/execute pipeline.

---
 rtl/run_sequencer_pkg.sv | 21 ++
 rtl/run_seq_fifo.sv | 47 ++++
 rtl/run_sequencer.sv | 179 +++++++++++++++++
 tb/tb_run_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/run_sequencer_pkg.sv
// Shared encodings and widths for the run sequencer and the execute datapath it drives.
package run_sequencer_pkg;

    localparam int unsigned OPC_W = 3;
    localparam int unsigned REG_W = 48;

    typedef enum logic [1:0] {
        KIND_A    = 2'd0,
        KIND_B    = 2'd1,
        KIND_C    = 2'd2,
        KIND_PROG = 2'd3
    } load_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/run_seq_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers; a push on a full FIFO lands only if a pop happens too.
module run_seq_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full_c,
    output logic         empty_c,
    output logic [W-1:0] head_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         wr_en;
    logic         rd_en;

    always_comb begin
        empty_c = (wr_ptr == rd_ptr);
        full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        rd_en   = pop && !empty_c;
        wr_en   = push && (!full_c || rd_en);
        head_c  = empty_c ? '0 : mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage is not reset; head_c masks it while empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/run_sequencer.sv
// Host-facing controller: serial register load, opcode memory, run control and output FIFO.
// Optional run cycle limit enabled by defining RUN_SEQ_TIMEOUT_EN.
module run_sequencer #(
    parameter int unsigned REG_W       = run_sequencer_pkg::REG_W,
    parameter int unsigned PROG_DEPTH  = 16,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [1:0]                    load_kind,
    input  logic [$clog2(PROG_DEPTH)-1:0] load_addr,
    input  logic [REG_W-1:0]              load_data,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          timed_out,
    output logic                          overflow,
    output logic                          init_regs,
    output logic                          a_bit,
    output logic                          b_bit,
    output logic                          c_bit,
    output logic                          core_rst_n,
    input  logic [$clog2(PROG_DEPTH)-1:0] fetch_addr,
    output logic [2:0]                    fetch_data,
    input  logic                          core_halt,
    input  logic [2:0]                    core_out,
    input  logic                          core_out_valid,
    output logic [2:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready
);

    import run_sequencer_pkg::*;

    localparam int unsigned CNT_W = $clog2(REG_W);

    state_e           state, state_nxt;
    load_kind_e       lane, lane_nxt;
    load_kind_e       kind_in;
    logic [REG_W-1:0] shift_reg, shift_nxt;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic             timed_out_nxt;
    logic             overflow_nxt;
    logic             push_c, pop_c, full_c, empty_c;
    logic [OPC_W-1:0] prog_mem [PROG_DEPTH];

`ifdef RUN_SEQ_TIMEOUT_EN
    logic [31:0] run_cyc, run_cyc_nxt;
    logic        limit_c;
    assign limit_c = (run_cyc == 32'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYC);
`endif

    assign kind_in = load_kind_e'(load_kind);
    assign push_c  = (state == ST_RUN) && core_out_valid;
    assign pop_c   = out_valid && out_ready;

    // Next-state and next-value logic for every registered output.
    always_comb begin
        state_nxt     = state;
        lane_nxt      = lane;
        shift_nxt     = shift_reg;
        bit_cnt_nxt   = bit_cnt;
        timed_out_nxt = timed_out;
        overflow_nxt  = overflow | (push_c && full_c && !pop_c);
`ifdef RUN_SEQ_TIMEOUT_EN
        run_cyc_nxt   = run_cyc;
`endif
        case (state)
            ST_IDLE: begin
                if (load_valid) begin
                    if (kind_in != KIND_PROG) begin
                        lane_nxt    = kind_in;
                        shift_nxt   = load_data;
                        bit_cnt_nxt = CNT_W'(REG_W - 1);
                        state_nxt   = ST_SHIFT;
                    end
                end else if (start) begin
                    timed_out_nxt = 1'b0;
                    overflow_nxt  = 1'b0;
`ifdef RUN_SEQ_TIMEOUT_EN
                    run_cyc_nxt   = '0;
`endif
                    state_nxt     = ST_RUN;
                end
            end
            ST_SHIFT: begin
                shift_nxt   = shift_reg << 1;
                bit_cnt_nxt = bit_cnt - CNT_W'(1);
                if (bit_cnt == '0) state_nxt = ST_IDLE;
            end
            ST_RUN: begin
`ifdef RUN_SEQ_TIMEOUT_EN
                run_cyc_nxt = run_cyc + 32'd1;
                if (core_halt) begin
                    state_nxt = ST_DONE;
                end else if (limit_c) begin
                    timed_out_nxt = 1'b1;
                    state_nxt     = ST_DONE;
                end
`else
                if (core_halt) state_nxt = ST_DONE;
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            lane       <= KIND_A;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            load_ready <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            timed_out  <= 1'b0;
            overflow   <= 1'b0;
            init_regs  <= 1'b0;
            a_bit      <= 1'b0;
            b_bit      <= 1'b0;
            c_bit      <= 1'b0;
            core_rst_n <= 1'b0;
        end else begin
            state      <= state_nxt;
            lane       <= lane_nxt;
            shift_reg  <= shift_nxt;
            bit_cnt    <= bit_cnt_nxt;
            load_ready <= (state_nxt == ST_IDLE);
            busy       <= (state_nxt != ST_IDLE);
            done       <= (state_nxt == ST_DONE);
            timed_out  <= timed_out_nxt;
            overflow   <= overflow_nxt;
            init_regs  <= (state_nxt == ST_SHIFT);
            a_bit      <= (state_nxt == ST_SHIFT) && (lane_nxt == KIND_A) && shift_nxt[REG_W-1];
            b_bit      <= (state_nxt == ST_SHIFT) && (lane_nxt == KIND_B) && shift_nxt[REG_W-1];
            c_bit      <= (state_nxt == ST_SHIFT) && (lane_nxt == KIND_C) && shift_nxt[REG_W-1];
            core_rst_n <= (state_nxt == ST_RUN);
        end
    end

`ifdef RUN_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_cyc <= '0;
        else        run_cyc <= run_cyc_nxt;
    end
`endif

    // Opcode memory: written only from IDLE, read combinationally by fetch.
    always_ff @(posedge clk) begin
        if ((state == ST_IDLE) && load_valid && (kind_in == KIND_PROG))
            prog_mem[load_addr] <= load_data[OPC_W-1:0];
    end

    assign fetch_data = prog_mem[fetch_addr];

    run_seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (OPC_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_c),
        .push_data (core_out),
        .pop       (pop_c),
        .full_c    (full_c),
        .empty_c   (empty_c),
        .head_c    (out_data)
    );

    assign out_valid = !empty_c;

endmodule

// File: tb/tb_run_sequencer.sv
// Scoreboard bench for run_sequencer: serial load, opcode memory, run/FIFO, overflow, reset mid-shift.
module tb_run_sequencer;

`ifdef RUN_SEQ_TIMEOUT_EN
    localparam int unsigned TB_TO = 100;
`else
    localparam int unsigned TB_TO = 65535;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [1:0]  load_kind = 2'd0;
    logic [3:0]  load_addr = 4'd0;
    logic [47:0] load_data = '0;
    logic        start = 1'b0;
    logic        busy, done, timed_out, overflow, init_regs;
    logic        a_bit, b_bit, c_bit, core_rst_n;
    logic [3:0]  fetch_addr = 4'd0;
    logic [2:0]  fetch_data;
    logic        core_halt = 1'b0;
    logic [2:0]  core_out = 3'd0;
    logic        core_out_valid = 1'b0;
    logic [2:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] exp_q [$];
    logic       bit_q [$];

    run_sequencer #(
        .REG_W       (48),
        .PROG_DEPTH  (16),
        .FIFO_DEPTH  (16),
        .TIMEOUT_CYC (TB_TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .load_kind      (load_kind),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .timed_out      (timed_out),
        .overflow       (overflow),
        .init_regs      (init_regs),
        .a_bit          (a_bit),
        .b_bit          (b_bit),
        .c_bit          (c_bit),
        .core_rst_n     (core_rst_n),
        .fetch_addr     (fetch_addr),
        .fetch_data     (fetch_data),
        .core_halt      (core_halt),
        .core_out       (core_out),
        .core_out_valid (core_out_valid),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pop every FIFO entry and compare against the scoreboard.
    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int k = 0; k < 40 && out_valid; k++) begin
            if (exp_q.size() == 0) check({tag, "_extra"}, 64'(out_data), 64'hx);
            else                   check(tag, 64'(out_data), 64'(exp_q.pop_front()));
            tick();
        end
        out_ready = 1'b0;
        check({tag, "_left"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic halt_run();
        core_halt = 1'b1;
        tick();
        core_halt = 1'b0;
        check("done_pulse", 64'(done), 64'd1);
        check("done_core_rst_n", 64'(core_rst_n), 64'd0);
        tick();
        check("done_single", 64'(done), 64'd0);
        check("idle_after_done", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] a_val;
        logic [2:0]  ops [6];
        logic [2:0]  vals [5];
        int          n;
        a_val = 48'h0000_0000_C5A3;
        ops   = '{3'd0, 3'd1, 3'd5, 3'd4, 3'd3, 3'd0};
        vals  = '{3'd4, 3'd6, 3'd3, 3'd0, 3'd1};

        #12;
        check("rst_load_ready", 64'(load_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_flags", 64'({done, timed_out, overflow, init_regs}), 64'd0);
        check("rst_bits", 64'({a_bit, b_bit, c_bit, core_rst_n}), 64'd0);
        check("rst_fifo", 64'({out_valid, out_data}), 64'd0);
        rst_n = 1'b1;
        tick();

        // Serial load of A, MSB first
        for (int i = 47; i >= 0; i--) bit_q.push_back(a_val[i]);
        load_valid = 1'b1; load_kind = 2'd0; load_data = a_val;
        tick();
        load_valid = 1'b0;
        n = 0;
        for (int k = 0; k < 100 && init_regs; k++) begin
            if (bit_q.size() == 0) check("a_bit_extra", 64'(a_bit), 64'hx);
            else                   check("a_bit", 64'(a_bit), 64'(bit_q.pop_front()));
            check("bc_bits_zero", 64'({b_bit, c_bit}), 64'd0);
            check("shift_load_ready", 64'(load_ready), 64'd0);
            n++;
            tick();
        end
        check("shift_len", 64'(n), 64'd48);
        check("shift_load_ready_back", 64'(load_ready), 64'd1);
        check("shift_bits_idle", 64'({a_bit, b_bit, c_bit}), 64'd0);

        // Opcode memory
        for (int i = 0; i < 6; i++) begin
            load_valid = 1'b1; load_kind = 2'd3; load_addr = 4'(i);
            load_data = {45'h1fff_ffff_fff, ops[i]};
            tick();
        end
        load_valid = 1'b0;
        check("prog_stays_idle", 64'({busy, load_ready}), 64'd1);
        for (int i = 0; i < 6; i++) begin
            fetch_addr = 4'(i);
            #1;
            check("fetch_data", 64'(fetch_data), 64'(ops[i]));
        end

        // Normal run with five outputs
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_core_rst_n", 64'(core_rst_n), 64'd1);
        check("run_busy", 64'({busy, load_ready}), 64'b10);
        for (int i = 0; i < 5; i++) begin
            core_out_valid = 1'b1; core_out = vals[i]; exp_q.push_back(vals[i]);
            tick();
        end
        core_out_valid = 1'b0;
        halt_run();
        check("run_timed_out", 64'(timed_out), 64'd0);
        drain("run_pop");
        check("run_overflow", 64'(overflow), 64'd0);

        // Overflow: 17 outputs into a 16-deep FIFO with no pops
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 17; i++) begin
            core_out_valid = 1'b1; core_out = 3'((i * 5 + 2) % 8);
            if (i < 16) exp_q.push_back(3'((i * 5 + 2) % 8));
            tick();
            check("ovf_flag", 64'(overflow), 64'(i == 16));
        end
        core_out_valid = 1'b0;
        halt_run();
        check("ovf_sticky", 64'(overflow), 64'd1);
        drain("ovf_pop");
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ovf_cleared", 64'(overflow), 64'd0);
        halt_run();

        // start and load together: load wins; then reset mid-shift
        load_valid = 1'b1; load_kind = 2'd1; start = 1'b1;
        load_data = 48'h8000_1234_5678;
        tick();
        load_valid = 1'b0; start = 1'b0;
        check("sl_init_regs", 64'(init_regs), 64'd1);
        check("sl_no_run", 64'(core_rst_n), 64'd0);
        check("sl_b_msb", 64'({a_bit, b_bit, c_bit}), 64'b010);
        for (int i = 0; i < 19; i++) tick();
        check("sl_cycle20", 64'(init_regs), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_init_regs", 64'(init_regs), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_bits", 64'({load_ready, b_bit}), 64'b10);
        #1;
        rst_n = 1'b1;
        tick();
        check("rst_mid_idle", 64'({busy, init_regs}), 64'd0);

`ifdef RUN_SEQ_TIMEOUT_EN
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            n++;
            tick();
        end
        check("to_cycles", 64'(n), 64'd100);
        check("to_done", 64'(done), 64'd1);
        check("to_flag", 64'(timed_out), 64'd1);
        check("to_core_rst_n", 64'(core_rst_n), 64'd0);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
